addsub_serial: RTL

Parametrised digit-serial adder/subtractor, the next generation of the team's 4-bit ripple adder. It accepts two WIDTH-bit operands and a mode bit over a valid/ready handshake, then computes DIGIT bits per clock through a registered carry chain. It presents the result with carry/borrow and signed overflow over a second valid/ready handshake. It sits in datapaths where area matters more than single-cycle latency, trading WIDTH/DIGIT cycles for a DIGIT-wide ripple slice.

---
 rtl/addsub_pkg.sv | 23 ++
 rtl/addsub_digit.sv | 29 ++
 rtl/addsub_serial.sv | 116 +++++++++++
 3 files changed

// File: rtl/addsub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: FSM state encoding
// and a constant-friendly clog2 for sizing the digit counter.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/addsub_digit.sv
// DIGIT-wide combinational ripple of full-adder cells. c_msb is the carry into
// the top bit, needed alongside cout to detect signed overflow.
module addsub_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    logic [DIGIT:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < DIGIT; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
    end

    assign cout  = c[DIGIT];
    assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial adder/subtractor: DIGIT bits per clock through a registered carry,
// operands in and result out over valid/ready handshakes.
module addsub_serial
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output state_t           state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // in_ready is high only in IDLE, out_valid only in DONE; neither depends
    // combinationally on the partner's signal.

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (clog2(N) < 1) ? 1 : clog2(N);

    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
        $error("addsub_serial: DIGIT must divide WIDTH exactly");
    end

    state_t          state_q, state_d;
    logic [WIDTH-1:0] a_sh, b_sh, sum_r;
    logic [WIDTH-1:0] a_nxt, b_nxt, sum_nxt;
    logic            carry_r, ovf_r;
    logic [CW-1:0]   cnt;
    logic [DIGIT-1:0] d_s;
    logic            d_cout, d_cmsb;
    logic            last_step;

    assign last_step = (cnt == CW'(N - 1));

    addsub_digit #(.DIGIT(DIGIT)) u_digit (
        .a     (a_sh[DIGIT-1:0]),
        .b     (b_sh[DIGIT-1:0]),
        .cin   (carry_r),
        .s     (d_s),
        .cout  (d_cout),
        .c_msb (d_cmsb)
    );

    // Results enter at the top of the sum register so the first digit ends at the LSB.
    if (DIGIT == WIDTH) begin : g_single
        assign a_nxt   = '0;
        assign b_nxt   = '0;
        assign sum_nxt = d_s;
    end else begin : g_multi
        assign a_nxt   = a_sh >> DIGIT;
        assign b_nxt   = b_sh >> DIGIT;
        assign sum_nxt = {d_s, sum_r[WIDTH-1:DIGIT]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = RUN;
            RUN:     if (last_step) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Subtraction is A + ~B + 1: invert B at load and seed the carry with sub.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh    <= '0;
            b_sh    <= '0;
            sum_r   <= '0;
            carry_r <= 1'b0;
            ovf_r   <= 1'b0;
            cnt     <= '0;
        end else if (state_q == IDLE && in_valid) begin
            a_sh    <= a;
            b_sh    <= b ^ {WIDTH{sub}};
            carry_r <= sub;
            cnt     <= '0;
        end else if (state_q == RUN) begin
            a_sh    <= a_nxt;
            b_sh    <= b_nxt;
            sum_r   <= sum_nxt;
            carry_r <= d_cout;
            if (last_step) begin
                ovf_r <= d_cmsb ^ d_cout;
                cnt   <= '0;
            end else begin
                cnt   <= cnt + 1'b1;
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_r;
    assign carry_out = carry_r;
    assign overflow  = ovf_r;
    assign state     = state_q;

endmodule
